// File: rtl/mdu_ctrl.sv
// Iterative 32x32 multiply / divide unit: a three-state controller with
// a shift-add multiplier and a restoring divider on one operand datapath.
module mdu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        dbz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;

  logic [1:0]  op_q;      // op[1]: divide, op[0]: signed
  logic        sa_q;      // sign of a (signed ops only)
  logic        sb_q;      // sign of b (signed ops only)
  logic [31:0] a_q;       // |a|: multiplicand, or dividend shifting into quotient
  logic [31:0] b_q;       // |b|: multiplier shifting right, or divisor
  logic [31:0] araw_q;    // a exactly as captured, returned on divide-by-zero
  logic [63:0] acc_q;     // product accumulator
  logic [32:0] rem_q;     // partial remainder
  logic [4:0]  cnt_q;     // iteration index
  logic        fin_q;     // all 32 iterations are complete
  logic [31:0] hi_q, lo_q;
  logic        dbz_q;

  logic [32:0] mul_sum;
  logic [33:0] div_diff;
  logic [31:0] res_hi, res_lo;
  logic        res_dbz;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    logic signed [31:0] s;
    s = -$signed(v);
    return $unsigned(s);
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    logic signed [63:0] s;
    s = -$signed(v);
    return $unsigned(s);
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: start only matters in IDLE; the finishing RUN cycle after
  // the 32nd iteration applies sign fix-up and enters DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (fin_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One iteration step of each algorithm. The shifted partial remainder is
  // below 2^33, so bit 33 of the difference is the borrow.
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (b_q[0] ? a_q : 32'd0)};
    div_diff = {rem_q, a_q[31]} - {2'b00, b_q};
  end

  // Final result with sign correction; a zero divisor returns the dividend
  // untouched and an all-ones quotient.
  always_comb begin
    res_hi  = acc_q[63:32];
    res_lo  = acc_q[31:0];
    res_dbz = 1'b0;
    if (!op_q[1]) begin
      if (op_q[0] && (sa_q ^ sb_q)) {res_hi, res_lo} = neg64(acc_q);
    end else if (b_q == 32'd0) begin
      res_hi  = araw_q;
      res_lo  = 32'hFFFF_FFFF;
      res_dbz = 1'b1;
    end else begin
      res_lo = (op_q[0] && (sa_q ^ sb_q)) ? neg32(a_q) : a_q;
      res_hi = (op_q[0] && sa_q) ? neg32(rem_q[31:0]) : rem_q[31:0];
    end
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= 2'b00;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      araw_q <= 32'd0;
      acc_q  <= 64'd0;
      rem_q  <= 33'd0;
      cnt_q  <= 5'd0;
      fin_q  <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      dbz_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            sa_q   <= op[0] & a[31];
            sb_q   <= op[0] & b[31];
            a_q    <= (op[0] & a[31]) ? neg32(a) : a;
            b_q    <= (op[0] & b[31]) ? neg32(b) : b;
            araw_q <= a;
            acc_q  <= 64'd0;
            rem_q  <= 33'd0;
            cnt_q  <= 5'd0;
            fin_q  <= 1'b0;
          end
        end
        RUN: begin
          if (!fin_q) begin
            if (op_q[1]) begin
              if (div_diff[33]) begin
                rem_q <= {rem_q[31:0], a_q[31]};
                a_q   <= {a_q[30:0], 1'b0};
              end else begin
                rem_q <= div_diff[32:0];
                a_q   <= {a_q[30:0], 1'b1};
              end
            end else begin
              acc_q <= {mul_sum, acc_q[31:1]};
              b_q   <= {1'b0, b_q[31:1]};
            end
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) fin_q <= 1'b1;
          end else begin
            hi_q  <= res_hi;
            lo_q  <= res_lo;
            dbz_q <= res_dbz;
          end
        end
        DONE: dbz_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign dbz  = done & dbz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus pushes expected results, a
// negedge monitor pops and compares whenever done is presented.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic prev_done = 1'b0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];

  mdu_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo),
    .dbz   (dbz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compare every presented result against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (dbz && !done) begin
      checks++;
      errors++;
      $display("FAIL dbz_without_done: got dbz=1 expected 0 at cycle %0d", cyc);
    end
    if (done) begin
      if (prev_done) begin
        checks++;
        errors++;
        $display("FAIL done_width: got done high 2 cycles expected 1");
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done hi=%0h lo=%0h expected no done", hi, lo);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_hi"}, 64'(hi), 64'(e.hi));
        chk({e.name, "_lo"}, 64'(lo), 64'(e.lo));
        chk({e.name, "_dbz"}, 64'(dbz), 64'(e.dbz));
        chk({e.name, "_latency"}, 64'(cyc - e.cyc), 64'd33);
      end
    end
    prev_done = done;
  end

  // Start an operation once idle; after capture the inputs are scrambled.
  task automatic issue(input logic [1:0] o, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] eh, input logic [31:0] el, input logic ed,
                       input bit push, input string nm);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk({nm, "_idle_timeout"}, 64'(busy), 64'd0);
    op = o;
    a = ia;
    b = ib;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (push) begin
      e.hi = eh;
      e.lo = el;
      e.dbz = ed;
      e.cyc = cyc;
      e.name = nm;
      sb.push_back(e);
    end
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || sb.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy || sb.size() != 0) chk({nm, "_drain_timeout"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within 200000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi",   64'(hi),   64'd0);
    chk("rst_lo",   64'(lo),   64'd0);
    chk("rst_dbz",  64'(dbz),  64'd0);
    reset = 1'b0;

    // Directed vectors with hand-computed results.
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1, "multu_max");
    issue(2'b01, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1, "mult_m3x5");
    issue(2'b01, 32'hFFFF_FFFC, 32'hFFFF_FFFA, 32'h0000_0000, 32'h0000_0018, 1'b0, 1, "mult_m4xm6");
    issue(2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1, "div_m7d2");
    issue(2'b11, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1, "div_7dm2");
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1, "div_min_m1");
    issue(2'b10, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1, "divu_max_1");
    issue(2'b10, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1, "divu_dbz");
    issue(2'b11, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, 1, "div_dbz");
    wait_idle("directed");

    // Start pulses during RUN cycles 5 and 20 and in DONE must be ignored.
    issue(2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 1, "multu_ign");
    repeat (5) @(negedge clk);
    op = 2'b10; a = 32'd99; b = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    op = 2'b01; a = 32'd5; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("ign_done_seen", 64'(done), 64'd1);
    op = 2'b00; a = 32'd2; b = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_done_start_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("ign_done_start_busy2", 64'(busy), 64'd0);
    chk("ign_hold_hi", 64'(hi), 64'd1);
    chk("ign_hold_lo", 64'(lo), 64'd0);

    // Reset in the middle of an operation aborts it without writing hi/lo.
    issue(2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1, "multu_3x4");
    wait_idle("multu_3x4");
    issue(2'b10, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 0, "divu_abort");
    repeat (10) @(negedge clk);
    chk("run_hold_hi", 64'(hi), 64'd0);
    chk("run_hold_lo", 64'(lo), 64'd12);
    chk("run_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hi",   64'(hi),   64'd0);
    chk("abort_lo",   64'(lo),   64'd0);
    chk("abort_dbz",  64'(dbz),  64'd0);
    reset = 1'b0;
    issue(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1, "divu_100d7");
    wait_idle("final");
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
